// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path and the planned transmitter.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } rx_state_t;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DATA_BITS  = 8;
   localparam int unsigned MID_SAMPLE = 8;

   // Wide enough to count every tick of a start + data + stop frame.
   localparam int unsigned OS_CNT_W  = $clog2(OVERSAMPLE * (DATA_BITS + 2));
   localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

   // Bit centres fall where the tick count before increment has MID_SAMPLE-1 in its low nibble.
   function automatic logic is_mid_sample(input logic [OS_CNT_W-1:0] os_cnt);
      return os_cnt[3:0] == 4'(MID_SAMPLE - 1);
   endfunction

endpackage

// File: rtl/uart_reading_rx_if.sv
// Serial line plus received-reading bus between the UART front end and its consumer.
interface uart_reading_rx_if;
   import uart_pkg::*;

   logic                 rxd;
   logic [DATA_BITS-1:0] reading;
   logic                 reading_valid;
   logic                 frame_err;

   modport master (
      output rxd,
      input  reading,
      input  reading_valid,
      input  frame_err
   );

   modport slave (
      input  rxd,
      output reading,
      output reading_valid,
      output frame_err
   );

endinterface

// File: rtl/uart_baud_tick.sv
// 16x oversample tick divider with synchronous clear; shared by UART rx and tx.
module uart_baud_tick #(
   parameter int unsigned CLK_DIV = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   output logic tick_o
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_d;

   // tick_o is registered one cycle ahead so it is high exactly while the count sits at CLK_DIV-1.
   always_comb begin
      cnt_d  = cnt_q + CNT_W'(1);
      tick_d = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else begin
         if (cnt_q == CNT_W'(CLK_DIV - 1)) cnt_d = '0;
         if (cnt_q == CNT_W'(CLK_DIV - 2)) tick_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         tick_o <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_o <= tick_d;
      end
   end

endmodule

// File: rtl/uart_reading_rx.sv
// 8N1 UART receiver presenting each correctly framed byte as the controller's reading.
module uart_reading_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_DIV = 27
) (
   input  logic             clk,
   input  logic             reset,
   uart_reading_rx_if.slave bus
);

   logic                 sync1_q, rx_s_q, rx_d_q;
   logic                 fall_c, clear_c, tick, sample_c;
   rx_state_t            state_q, state_d;
   logic [OS_CNT_W-1:0]  os_cnt_q, os_cnt_d;
   logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] reading_q, reading_d;
   logic                 valid_q, valid_d;
   logic                 err_q, err_d;

   // Synchronizer and edge register idle high so reset never looks like a start edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rx_s_q  <= 1'b1;
         rx_d_q  <= 1'b1;
      end else begin
         sync1_q <= bus.rxd;
         rx_s_q  <= sync1_q;
         rx_d_q  <= rx_s_q;
      end
   end

   assign fall_c  = rx_d_q & ~rx_s_q;
   assign clear_c = (state_q == IDLE) && fall_c;

   uart_baud_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_baud_tick (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear_c),
      .tick_o  (tick)
   );

   assign sample_c = tick && is_mid_sample(os_cnt_q);

   always_comb begin
      state_d   = state_q;
      os_cnt_d  = os_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      reading_d = reading_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;

      if (state_q != IDLE && tick) os_cnt_d = os_cnt_q + OS_CNT_W'(1);

      unique case (state_q)
         IDLE: begin
            if (fall_c) begin
               state_d  = START;
               os_cnt_d = '0;
            end
         end
         START: begin
            if (sample_c) begin
               if (!rx_s_q) begin
                  state_d   = DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            if (sample_c) begin
               shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
               if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) state_d = STOP;
               else bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            end
         end
         STOP: begin
            // Return to IDLE at the stop-bit centre so a back-to-back start edge is caught.
            if (sample_c) begin
               if (rx_s_q) begin
                  reading_d = shift_q;
                  valid_d   = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         os_cnt_q  <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         reading_q <= '0;
         valid_q   <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         os_cnt_q  <= os_cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         reading_q <= reading_d;
         valid_q   <= valid_d;
         err_q     <= err_d;
      end
   end

   assign bus.reading       = reading_q;
   assign bus.reading_valid = valid_q;
   assign bus.frame_err     = err_q;

endmodule

// File: tb/tb_uart_reading_rx.sv
// Directed bench for uart_reading_rx at CLK_DIV=4 (64 clk cycles per bit).
module tb_uart_reading_rx;
   import uart_pkg::*;

   localparam int unsigned CLK_DIV = 4;
   localparam int          BIT     = 64;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   int vectors     = 0;
   int miscompares = 0;
   int valid_cnt   = 0;
   int err_cnt     = 0;
   int overlap_cnt = 0;
   int wide_cnt    = 0;
   logic prev_v = 1'b0;
   logic prev_e = 1'b0;

   always #5 clk = ~clk;

   uart_reading_rx_if bus ();

   uart_reading_rx #(
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Pulse monitor: counts pulses and flags overlapping or multi-cycle pulses.
   always @(negedge clk) begin
      if (reset) begin
         if (bus.reading_valid) valid_cnt++;
         if (bus.frame_err) err_cnt++;
         if (bus.reading_valid && bus.frame_err) overlap_cnt++;
         if ((bus.reading_valid && prev_v) || (bus.frame_err && prev_e)) wide_cnt++;
      end
      prev_v = bus.reading_valid;
      prev_e = bus.frame_err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      bus.rxd = 1'b0;
      wait_cycles(BIT);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = d[i];
         wait_cycles(BIT);
      end
      bus.rxd = stop;
      wait_cycles(BIT);
      bus.rxd = 1'b1;
   endtask

   initial begin
      logic [7:0] aa;
      aa      = 8'hAA;
      bus.rxd = 1'b1;
      reset   = 1'b0;
      wait_cycles(5);
      check("rst_reading", 32'(bus.reading), 32'h00);
      check("rst_valid", 32'(bus.reading_valid), 32'h0);
      check("rst_err", 32'(bus.frame_err), 32'h0);

      reset = 1'b1;
      wait_cycles(2000);
      check("idle_reading", 32'(bus.reading), 32'h00);
      check("idle_valid_cnt", 32'(valid_cnt), 32'd0);
      check("idle_err_cnt", 32'(err_cnt), 32'd0);

      send(8'hC8, 1'b1);
      check("c8_valid_cnt", 32'(valid_cnt), 32'd1);
      check("c8_reading", 32'(bus.reading), 32'hC8);

      send(8'hF5, 1'b1);
      check("f5_valid_cnt", 32'(valid_cnt), 32'd2);
      check("f5_reading", 32'(bus.reading), 32'hF5);
      send(8'h0A, 1'b1);
      check("0a_valid_cnt", 32'(valid_cnt), 32'd3);
      check("0a_reading", 32'(bus.reading), 32'h0A);
      check("b2b_err_cnt", 32'(err_cnt), 32'd0);

      bus.rxd = 1'b0;
      wait_cycles(20);
      bus.rxd = 1'b1;
      wait_cycles(200);
      check("glitch_valid_cnt", 32'(valid_cnt), 32'd3);
      check("glitch_err_cnt", 32'(err_cnt), 32'd0);
      check("glitch_reading", 32'(bus.reading), 32'h0A);

      send(8'h55, 1'b0);
      wait_cycles(BIT);
      check("ferr_err_cnt", 32'(err_cnt), 32'd1);
      check("ferr_valid_cnt", 32'(valid_cnt), 32'd3);
      check("ferr_reading", 32'(bus.reading), 32'h0A);
      send(8'h33, 1'b1);
      check("33_valid_cnt", 32'(valid_cnt), 32'd4);
      check("33_reading", 32'(bus.reading), 32'h33);

      bus.rxd = 1'b0;
      wait_cycles(2000);
      bus.rxd = 1'b1;
      wait_cycles(100);
      check("break_err_cnt", 32'(err_cnt), 32'd2);
      check("break_valid_cnt", 32'(valid_cnt), 32'd4);
      check("break_reading", 32'(bus.reading), 32'h33);
      send(8'h81, 1'b1);
      check("81_valid_cnt", 32'(valid_cnt), 32'd5);
      check("81_reading", 32'(bus.reading), 32'h81);

      // Reset lands 20 cycles into data bit 4 of 0xAA and is held until the line idles.
      bus.rxd = 1'b0;
      wait_cycles(BIT);
      for (int i = 0; i < 4; i++) begin
         bus.rxd = aa[i];
         wait_cycles(BIT);
      end
      bus.rxd = aa[4];
      wait_cycles(20);
      reset = 1'b0;
      wait_cycles(1);
      check("midrst_reading", 32'(bus.reading), 32'h00);
      check("midrst_valid", 32'(bus.reading_valid), 32'h0);
      wait_cycles(BIT - 21);
      for (int i = 5; i < 8; i++) begin
         bus.rxd = aa[i];
         wait_cycles(BIT);
      end
      bus.rxd = 1'b1;
      wait_cycles(BIT + 100);
      reset = 1'b1;
      wait_cycles(200);
      check("postrst_valid_cnt", 32'(valid_cnt), 32'd5);
      check("postrst_err_cnt", 32'(err_cnt), 32'd2);
      check("postrst_reading", 32'(bus.reading), 32'h00);
      send(8'h12, 1'b1);
      check("12_valid_cnt", 32'(valid_cnt), 32'd6);
      check("12_reading", 32'(bus.reading), 32'h12);
      check("12_err_cnt", 32'(err_cnt), 32'd2);

      check("pulse_overlap", 32'(overlap_cnt), 32'd0);
      check("pulse_width", 32'(wide_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
